// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin front end that shares one floating-point
// multiplier between NUM_REQUESTERS sources. Two-stage pipeline (operand
// register -> result register) with valid/ready flow control, per-result
// exception flags and sticky flag accumulation.

// Combinational IEEE-style multiplier. Subnormal inputs are treated as zero
// and results below the normal range flush to signed zero with underflow.
// Any NaN input, or zero x infinity, yields the default NaN (sign set, quiet
// bit set); only zero x infinity raises invalid.
module floating_point_multiplier #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
  output logic                                   underflow,
  output logic                                   overflow,
  output logic                                   invalid
);
  localparam int E    = EXPONENT_WIDTH;
  localparam int M    = MANTISSA_WIDTH;
  localparam int W    = E + M + 1;
  localparam int PW   = 2 * M + 2;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;

  logic          sign;
  logic [E-1:0]  ea, eb;
  logic [M-1:0]  fa, fb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0] prod;
  logic [PW-2:0] norm;
  logic          guard, sticky, round_up;
  logic [M:0]    mant_r;
  int            exp_i;

  // Unpack, multiply significands, normalise, round, then handle specials.
  always_comb begin
    sign     = a[W-1] ^ b[W-1];
    ea       = a[W-2:M];
    eb       = b[W-2:M];
    fa       = a[M-1:0];
    fb       = b[M-1:0];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (fa == '0);
    b_inf    = (eb == '1) && (fb == '0);
    a_nan    = (ea == '1) && (fa != '0);
    b_nan    = (eb == '1) && (fb != '0);
    prod     = PW'({1'b1, fa}) * PW'({1'b1, fb});
    norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    guard    = norm[M];
    sticky   = |norm[M-1:0];
    round_up = (ROUND_TO_NEAREST != 0) && guard && (sticky || norm[M+1]);
    mant_r   = {1'b0, norm[PW-2:M+1]} + {{M{1'b0}}, round_up};
    exp_i    = int'(ea) + int'(eb) - BIAS + int'(prod[PW-1]) + int'(mant_r[M]);
    result    = {sign, exp_i[E-1:0], mant_r[M-1:0]};
    underflow = 1'b0;
    overflow  = 1'b0;
    invalid   = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      result  = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      invalid = (a_inf && b_zero) || (a_zero && b_inf);
    end else if (a_inf || b_inf) begin
      result = {sign, {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero || b_zero) begin
      result = {sign, {(W-1){1'b0}}};
    end else if (exp_i >= EMAX) begin
      result   = {sign, {E{1'b1}}, {M{1'b0}}};
      overflow = 1'b1;
    end else if (exp_i <= 0) begin
      result    = {sign, {(W-1){1'b0}}};
      underflow = 1'b1;
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int  EXPONENT_WIDTH   = 8,
  parameter int  MANTISSA_WIDTH   = 23,
  parameter int  ROUND_TO_NEAREST = 1,
  parameter int  NUM_REQUESTERS   = 4,
  localparam int W   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int IDW = ($clog2(NUM_REQUESTERS) > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQUESTERS-1:0]   in_valid,
  output logic [NUM_REQUESTERS-1:0]   in_ready,
  input  logic [NUM_REQUESTERS*W-1:0] in_a,
  input  logic [NUM_REQUESTERS*W-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W-1:0]                out_result,
  output logic [IDW-1:0]              out_id,
  output logic                        out_underflow,
  output logic                        out_overflow,
  output logic                        out_invalid,
  output logic [2:0]                  sticky_flags,
  input  logic                        flags_clear,
  output logic                        busy
);
  logic           vld_p1;
  logic [W-1:0]   a_p1, b_p1;
  logic [IDW-1:0] id_p1;
  logic [IDW-1:0] rr_ptr, gnt, gnt_next;
  logic           gnt_found, adv1, adv2, xfer;
  logic [W-1:0]   mul_result;
  logic           mul_uf, mul_of, mul_nv;
  int             idx;

  assign adv2 = !out_valid || out_ready;
  assign adv1 = !vld_p1 || adv2;
  assign busy = vld_p1 || out_valid;

  // Round-robin grant: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQUESTERS;
      if (!gnt_found && in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx[IDW-1:0];
      end
    end
    gnt_next = (gnt == IDW'(NUM_REQUESTERS - 1)) ? '0 : gnt + 1'b1;
    xfer     = gnt_found && adv1 && !rst;
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  // ---- stage 1: operand register ----
  // Stage-1 control: valid bit and round-robin pointer (moves only on transfer).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else if (xfer) begin
      vld_p1 <= 1'b1;
      rr_ptr <= gnt_next;
    end else if (adv1) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage-1 data: capture the granted requester's operand pair and index.
  always_ff @(posedge clk) begin
    if (xfer) begin
      a_p1  <= in_a[int'(gnt)*W +: W];
      b_p1  <= in_b[int'(gnt)*W +: W];
      id_p1 <= gnt;
    end
  end

  floating_point_multiplier #(
    .EXPONENT_WIDTH  (EXPONENT_WIDTH),
    .MANTISSA_WIDTH  (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST(ROUND_TO_NEAREST)
  ) u_mul (
    .a        (a_p1),
    .b        (b_p1),
    .result   (mul_result),
    .underflow(mul_uf),
    .overflow (mul_of),
    .invalid  (mul_nv)
  );

  // ---- stage 2: result register ----
  // Result register: load on advance, hold everything under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_id        <= '0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
      out_invalid   <= 1'b0;
    end else if (adv2) begin
      out_valid     <= vld_p1;
      out_result    <= mul_result;
      out_id        <= id_p1;
      out_underflow <= mul_uf;
      out_overflow  <= mul_of;
      out_invalid   <= mul_nv;
    end
  end

  // Sticky flags accumulate delivered results; a same-cycle clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 3'b000;
    end else if (flags_clear) begin
      sticky_flags <= 3'b000;
    end else if (out_valid && out_ready) begin
      sticky_flags <= sticky_flags | {out_invalid, out_overflow, out_underflow};
    end
  end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: directed steps with a scoreboard of expected
// products, plus a small-format instance for the narrow-parameter case.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_a, in_b;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_result;
  logic [1:0]     out_id;
  logic           out_underflow, out_overflow, out_invalid;
  logic [2:0]     sticky_flags;
  logic           flags_clear, busy;

  logic [2:0]  s_in_valid, s_in_ready;
  logic [23:0] s_in_a, s_in_b;
  logic        s_out_valid;
  logic [7:0]  s_out_result;
  logic [1:0]  s_out_id;
  logic        s_uf, s_of, s_nv, s_busy;
  logic [2:0]  s_sticky;

  fp_mul_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_id(out_id), .out_underflow(out_underflow),
    .out_overflow(out_overflow), .out_invalid(out_invalid),
    .sticky_flags(sticky_flags), .flags_clear(flags_clear), .busy(busy)
  );

  fp_mul_arbiter #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .NUM_REQUESTERS(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_result(s_out_result), .out_id(s_out_id), .out_underflow(s_uf),
    .out_overflow(s_of), .out_invalid(s_nv), .sticky_flags(s_sticky),
    .flags_clear(1'b0), .busy(s_busy)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          accepted = 0;
  exp_t        sb[$];
  logic [31:0] req_res[N];
  logic [2:0]  req_flg[N];
  logic        oneshot;
  logic [31:0] hold_r;
  logic [1:0]  hold_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] flg);
    in_a[i*W +: W] = a;
    in_b[i*W +: W] = b;
    req_res[i]     = res;
    req_flg[i]     = flg;
    in_valid[i]    = 1'b1;
  endtask

  // One clock: sample both handshakes, advance an edge, return at negedge.
  task automatic tick();
    logic [N-1:0] took;
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_id", out_id, e.id);
        chk("out_result", out_result, e.res);
        chk("out_flags", {out_invalid, out_overflow, out_underflow}, e.flg);
      end
    end
    chk("ready_onehot", ($countones(in_ready) <= 1), 1);
    took = in_valid & in_ready;
    for (int i = 0; i < N; i++) begin
      if (took[i]) begin
        sb.push_back('{id: 2'(i), res: req_res[i], flg: req_flg[i]});
        accepted++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (oneshot) in_valid = in_valid & ~took;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((sb.size() > 0 || in_valid != '0 || busy) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < bound, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    flags_clear = 1'b0; oneshot = 1'b1;
    s_in_valid = '0; s_in_a = '0; s_in_b = '0;
    @(negedge clk); @(negedge clk);
    // reset state, requests ignored while reset is high
    in_valid = '1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_id", out_id, 0);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("no_req_no_grant", in_ready, 0);
    @(negedge clk);

    // single product 3.0 x 2.0, one-cycle latency
    set_req(0, 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000);
    tick();
    chk("latency_not_yet", out_valid, 0);
    chk("busy_s1", busy, 1);
    tick();
    chk("latency_valid", out_valid, 1);
    chk("first_result", out_result, 32'h40C00000);
    drain(10);
    chk("idle_busy", busy, 0);

    // reset so arbitration starts from requester 0, then all four streaming
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    oneshot = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    set_req(2, 32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000);
    set_req(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
    for (int g = 0; g < 8; g++) begin
      #1;
      chk("rr_grant", in_ready, 1 << (g % 4));
      tick();
    end
    in_valid = '0;
    oneshot = 1'b1;
    drain(20);

    // back-pressure: three pending, exactly two accepted, output held
    out_ready = 1'b0;
    accepted = 0;
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    set_req(2, 32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000);
    tick();
    tick();
    chk("stall_valid", out_valid, 1);
    hold_r = out_result;
    hold_id = out_id;
    chk("stall_id", hold_id, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_result_stable", out_result, hold_r);
      chk("stall_id_stable", out_id, hold_id);
    end
    chk("stall_accepted", accepted, 2);
    out_ready = 1'b1;
    drain(20);

    // exceptions and sticky flags
    set_req(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    tick();
    set_req(0, 32'h00000000, 32'h7F800000, 32'hFFC00000, 3'b100);
    drain(20);
    chk("sticky_ovf_inv", sticky_flags, 3'b110);
    tick(); tick(); tick();
    chk("sticky_hold", sticky_flags, 3'b110);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    chk("sticky_cleared", sticky_flags, 3'b000);
    set_req(1, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    drain(20);
    chk("sticky_unf", sticky_flags, 3'b001);
    out_ready = 1'b0;
    set_req(2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    tick();
    tick();
    chk("clr_race_valid", out_valid, 1);
    out_ready = 1'b1;
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    chk("clear_wins", sticky_flags, 3'b000);
    drain(20);

    // asynchronous reset with both stages full
    set_req(3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    drain(20);
    chk("sticky_pre_rst", sticky_flags, 3'b010);
    out_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
    set_req(1, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    tick();
    tick();
    chk("full_valid", out_valid, 1);
    chk("full_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_sticky", sticky_flags, 0);
    chk("async_in_ready", in_ready, 0);
    sb.delete();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_req(2, 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000);
    #1;
    chk("grant_after_rst", in_ready, 4'b0100);
    drain(20);

    // narrow format, three requesters: 1.0 x 2.0 and grant wrap 2 -> 0
    s_in_a = {3{8'h38}};
    s_in_b = {3{8'h40}};
    s_in_valid = 3'b111;
    for (int g = 0; g < 7; g++) begin
      #1;
      chk("s_grant", s_in_ready, 1 << (g % 3));
      if (g >= 2) begin
        chk("s_out_valid", s_out_valid, 1);
        chk("s_out_id", s_out_id, (g - 2) % 3);
        chk("s_out_result", s_out_result, 8'h40);
        chk("s_flags", {s_nv, s_of, s_uf}, 3'b000);
      end
      @(negedge clk);
    end
    s_in_valid = '0;
    repeat (3) @(negedge clk);
    chk("s_idle", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width of every operand and result.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, mantissa field width; W = EXPONENT_WIDTH+MANTISSA_WIDTH+1.
REQ-003 SHALL have parameter ROUND_TO_NEAREST, default 1, passed unchanged to floating_point_multiplier (0 chop, 1 nearest).
REQ-004 SHALL have parameter NUM_REQUESTERS, default 4, range 2..16; IDW = max(1, clog2(NUM_REQUESTERS)).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  NUM_REQUESTERS  per-requester operand-pair valid.
REQ-008 in_ready  output  NUM_REQUESTERS  per-requester accept; at most one bit high.
REQ-009 in_a, in_b  input  NUM_REQUESTERS*W  packed operands; requester i at bits [i*W +: W].
REQ-010 out_valid  output  1  result register holds a valid product.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_result  output  W  product; out_id  output  IDW  requester index of product.
REQ-013 out_underflow, out_overflow, out_invalid  output  1 each  per-result exception flags.
REQ-014 sticky_flags  output  3  {invalid, overflow, underflow} OR-accumulated over delivered results.
REQ-015 flags_clear  input  1  synchronous clear of sticky_flags.
REQ-016 busy  output  1  high when either pipeline stage holds valid data.

Function
REQ-017 SHALL instantiate exactly one floating_point_multiplier, shared by all requesters, between stage 1 (operand register) and stage 2 (result register).
REQ-018 Stage-2 advance adv2 = !out_valid || out_ready; stage-1 advance adv1 = !s1_valid || adv2.
REQ-019 Round-robin arbiter: grant = first requester with in_valid high, searching from rr_ptr upward modulo NUM_REQUESTERS; in_ready[grant] = adv1, all others 0.
REQ-020 in_ready SHALL NOT depend combinationally on in_valid of the same requester beyond grant selection; no grant when no in_valid.
REQ-021 Transfer occurs when in_valid[i] && in_ready[i]; at that edge stage 1 loads in_a/in_b slice i, id i, s1_valid=1, and rr_ptr = (i+1) mod NUM_REQUESTERS.
REQ-022 rr_ptr SHALL NOT change in a cycle without transfer.
REQ-023 When adv1 and no transfer, s1_valid SHALL clear.
REQ-024 When adv2, stage 2 loads multiplier out, flags, s1 id and out_valid=s1_valid; otherwise stage 2 holds all values unchanged.
REQ-025 Latency: transfer at edge k -> out_valid=1 with that product after edge k+1; throughput one product per cycle with out_ready held high.
REQ-026 Out-of-order delivery SHALL NOT occur; results leave in acceptance order.
REQ-027 out_result, out_id and out flags SHALL stay stable while out_valid && !out_ready.
REQ-028 sticky_flags updates on out_valid && out_ready by OR-ing the three out flags; flags_clear same cycle wins (result 0, handshake flags discarded).
REQ-029 busy = s1_valid || out_valid.
REQ-030 Sequential logic SHALL contain no $display; multiplier results and flags SHALL pass through unmodified.

Reset
REQ-031 rst high SHALL immediately clear s1_valid, out_valid, rr_ptr=0, sticky_flags=0, out_result=0, out_id=0, all out flags=0; in_ready all 0 while rst high.
REQ-032 Reset mid-operation SHALL drop in-flight products; none is delivered after deassertion.
REQ-033 First arbitration after reset SHALL start from requester 0.

Verification
REQ-034 Requester 0 sends a=0x40400000, b=0x40000000, out_ready=1 -> out_result=0x40C00000, out_id=0, all flags 0, one cycle after transfer.
REQ-035 All four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle; out_id sequence identical.
REQ-036 out_ready=0 for 5 cycles with 3 requests pending -> exactly 2 accepted, out_result/out_id stable, then drained in order on out_ready=1.
REQ-037 a=0x7F000000, b=0x7F000000 -> out_result=0x7F800000, out_overflow=1; then 0x00000000 x 0x7F800000 -> 0xFFC00000, out_invalid=1; sticky_flags=3'b110 until flags_clear.
REQ-038 rst asserted asynchronously with s1 and s2 full -> out_valid, busy, sticky_flags 0 before next edge; after release requester 2 alone valid -> granted, out_id=2.
REQ-039 EXPONENT_WIDTH=4, MANTISSA_WIDTH=3, NUM_REQUESTERS=3: 0x38 x 0x40 (1.0 x 2.0) -> 0x40; round-robin wraps 2->0.
